sap1_ram_loader: RTL and testbench

Programming-mode front end for the SAP-1 16x8 memory array built from RAM cells. Accepts program bytes over a valid/ready handshake, drives address, data, select and write strobe into the array, and auto-increments the address. Hands the memory over to run mode when the load completes. Sits directly upstream of the RAM array, in the position of the front-panel switch loader.

---
 rtl/sap1_ram_loader_if.sv | 31 +++
 rtl/sap1_ram_loader.sv | 131 +++++++++++++
 tb/tb_sap1_ram_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sap1_ram_loader_if.sv
// Handshake and RAM-array bus between the loader and its surroundings.
//   master : drives start/stop and the program byte stream, observes the rest
//   slave  : the loader; accepts bytes and drives the RAM array and status
interface sap1_ram_loader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              stop;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic              ram_sel;
    logic              ram_w;
    logic              busy;
    logic              done;
    logic              run_en;
    logic [ADDR_W:0]   count;

    modport master (
        output start, stop, in_valid, in_data,
        input  in_ready, ram_addr, ram_d, ram_sel, ram_w, busy, done, run_en, count
    );

    modport slave (
        input  start, stop, in_valid, in_data,
        output in_ready, ram_addr, ram_d, ram_sel, ram_w, busy, done, run_en, count
    );
endinterface

// File: rtl/sap1_ram_loader.sv
// Programming-mode loader for the SAP-1 16x8 RAM array.
// Accepts program bytes over valid/ready, writes each one with a
// SETUP/STROBE/HOLD sequence so address and data bracket the write strobe,
// auto-increments the address and releases the array to run mode when done.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : slave side of sap1_ram_loader_if (handshake, RAM drive, status)
module sap1_ram_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    sap1_ram_loader_if.slave   bus
);
    localparam int unsigned         CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]   ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               stop_pend_q, stop_pend_d;
    logic               in_ready_q, in_ready_d;
    logic               sel_q, sel_d;
    logic               w_q, w_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next state, datapath updates, and output decode of the next state
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_ACCEPT;
                    addr_d      = '0;
                    count_d     = '0;
                    stop_pend_d = 1'b0;
                end
            end
            S_ACCEPT: begin
                // A transfer beats a simultaneous stop; the stop is kept for HOLD
                if (bus.in_valid) begin
                    state_d = S_SETUP;
                    data_d  = bus.in_data;
                    if (bus.stop) stop_pend_d = 1'b1;
                end else if (bus.stop) begin
                    state_d = S_DONE;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                if (bus.stop) stop_pend_d = 1'b1;
            end
            S_STROBE: begin
                state_d = S_HOLD;
                if (bus.stop) stop_pend_d = 1'b1;
            end
            S_HOLD: begin
                count_d     = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                addr_d      = addr_q + ADDR_W'(1);
                stop_pend_d = 1'b0;
                if (addr_q == ADDR_MAX || stop_pend_q || bus.stop) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_ACCEPT);
        sel_d      = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        w_d        = (state_d == S_STROBE);
        busy_d     = in_ready_d || sel_d;
        done_d     = (state_d == S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            in_ready_q  <= 1'b0;
            sel_q       <= 1'b0;
            w_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            in_ready_q  <= in_ready_d;
            sel_q       <= sel_d;
            w_q         <= w_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_d    = data_q;
    assign bus.ram_sel  = sel_q;
    assign bus.ram_w    = w_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.run_en   = done_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_sap1_ram_loader.sv
// Directed bench for sap1_ram_loader: full load, gapped stream, early stop,
// stop coincident with a transfer, reset mid-strobe, start while busy/done.
module tb_sap1_ram_loader;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic clr_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];

    sap1_ram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sap1_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen mid-cycle
    always @(negedge clk) begin
        if (clr_n && bus.ram_w) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_d);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !bus.in_ready; k++) step();
        chk("wait_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Offer one byte and return just after the edge that accepts it
    task automatic send(input logic [7:0] b, input bit stp, input bit keep_valid);
        bit acc;
        acc          = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.stop     = stp;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = bus.in_ready;
            step();
        end
        bus.stop = 1'b0;
        if (!keep_valid) bus.in_valid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
    endtask

    initial begin
        int n_start;
        int n_wr;
        bit gap_ok;

        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clr_n        = 1'b0;
        #1;
        // Reset values
        chk("rst_ctrl", 32'({bus.in_ready, bus.ram_sel, bus.ram_w, bus.busy, bus.done, bus.run_en}), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_d", 32'(bus.ram_d), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        #11 clr_n = 1'b1;
        step();
        chk("idle_ready", 32'(bus.in_ready), 32'd0);

        // Full load 0x10..0x1F, in_valid held high
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        pulse_start();
        n_start = cyc;
        chk("start_ready", 32'({bus.in_ready, bus.busy}), 32'b11);
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.done; k++) step();
        chk("full_done_cycle", 32'(cyc - n_start), 32'd64);
        chk("full_status", 32'({bus.done, bus.run_en, bus.busy, bus.in_ready}), 32'b1100);
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_addr", 32'(bus.ram_addr), 32'd0);
        chk("full_nwr", 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("full_wr", 32'({wr_addr[i], wr_data[i]}), 32'({4'(i), 8'(8'h10 + i)}));
        end

        // Gapped stream, then stop in ACCEPT after 5 bytes
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            gap_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (!bus.in_ready || bus.ram_w) gap_ok = 1'b0;
                step();
            end
            chk("gap_idle", 32'(gap_ok), 32'd1);
            send(8'(8'hA0 + i), 1'b0, 1'b0);
            chk("ph_setup", 32'({bus.ram_sel, bus.ram_w, bus.ram_addr, bus.ram_d}), 32'({2'b10, 4'(i), 8'(8'hA0 + i)}));
            step();
            chk("ph_strobe", 32'({bus.ram_sel, bus.ram_w, bus.ram_addr, bus.ram_d}), 32'({2'b11, 4'(i), 8'(8'hA0 + i)}));
            step();
            chk("ph_hold", 32'({bus.ram_sel, bus.ram_w, bus.ram_addr, bus.ram_d}), 32'({2'b10, 4'(i), 8'(8'hA0 + i)}));
            step();
            chk("ph_back", 32'({bus.in_ready, bus.ram_sel, bus.ram_w}), 32'b100);
        end
        send(8'hA3, 1'b0, 1'b0);
        send(8'hA4, 1'b0, 1'b0);
        wait_ready();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_done", 32'({bus.done, bus.busy}), 32'b10);
        chk("stop_count", 32'(bus.count), 32'd5);
        n_wr = wr_addr.size();
        for (int k = 0; k < 5; k++) step();
        chk("stop_nwr", 32'(wr_addr.size()), 32'd5);
        chk("stop_nwr_stable", 32'(n_wr), 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk("gap_wr", 32'({wr_addr[i], wr_data[i]}), 32'({4'(i), 8'(8'hA0 + i)}));
        end

        // Stop coincident with the third transfer
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send(8'h31, 1'b0, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        wait_ready();
        send(8'h33, 1'b1, 1'b0);
        step();
        step();
        chk("cstop_not_yet", 32'(bus.done), 32'd0);
        step();
        chk("cstop_done", 32'(bus.done), 32'd1);
        chk("cstop_count", 32'(bus.count), 32'd3);
        chk("cstop_nwr", 32'(wr_addr.size()), 32'd3);
        chk("cstop_last", 32'({wr_addr[2], wr_data[2]}), 32'({4'd2, 8'h33}));

        // Start in DONE restarts; start while busy is ignored
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        chk("restart", 32'({bus.done, bus.count, bus.in_ready}), 32'({1'b0, 5'd0, 1'b1}));
        send(8'h50, 1'b0, 1'b0);
        pulse_start();
        send(8'h51, 1'b0, 1'b0);
        wait_ready();
        pulse_start();
        send(8'h52, 1'b0, 1'b0);
        wait_ready();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("busy_start_count", 32'(bus.count), 32'd3);
        chk("busy_start_nwr", 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("busy_start_wr", 32'({wr_addr[i], wr_data[i]}), 32'({4'(i), 8'(8'h50 + i)}));
        end

        // Reset during STROBE of word 7
        pulse_start();
        for (int i = 0; i < 7; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
        send(8'h67, 1'b0, 1'b0);
        step();
        chk("pre_rst_strobe", 32'({bus.ram_w, bus.ram_addr}), 32'({1'b1, 4'd7}));
        #2 clr_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({bus.ram_w, bus.ram_sel, bus.busy, bus.in_ready, bus.done}), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        #3 clr_n = 1'b1;
        step();
        chk("post_rst_idle", 32'({bus.in_ready, bus.busy}), 32'd0);
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send(8'h77, 1'b0, 1'b0);
        step();
        step();
        chk("post_rst_nwr", 32'(wr_addr.size()), 32'd1);
        chk("post_rst_wr", 32'({wr_addr[0], wr_data[0]}), 32'({4'd0, 8'h77}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
